// File: rtl/dispatch_pkg.sv
// Shared types and constants for the dispatch queue: instruction classes,
// execution slot indices and the RV64 opcodes that drive slot steering.
package dispatch_pkg;

    typedef enum logic [1:0] {
        CLS_ALU = 2'd0,
        CLS_MDU = 2'd1,
        CLS_BRU = 2'd2
    } inst_class_e;

    localparam logic [1:0] SLOT_ALU0 = 2'd0;
    localparam logic [1:0] SLOT_ALU1 = 2'd1;
    localparam logic [1:0] SLOT_MDU  = 2'd2;
    localparam logic [1:0] SLOT_BRU  = 2'd3;

    // RV64 base opcodes (shared with main control)
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_OP_32  = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [6:0] F7_MULDIV  = 7'b0000001;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

endpackage

// File: rtl/dispatch_queue_classify.sv
// Instruction word -> execution class (ALU / MDU / BRU). Anything not
// recognised as a branch/jump or M-extension op is steered to an ALU.
module inst_classify
    import dispatch_pkg::*;
(
    input  logic [31:0]  inst,
    output inst_class_e  cls
);

    logic [6:0] opcode;
    logic [6:0] funct7;
    logic       unused_fields;

    assign opcode        = inst[6:0];
    assign funct7        = inst[31:25];
    assign unused_fields = ^inst[24:7];

    always_comb begin
        cls = CLS_ALU;
        case (opcode)
            OPC_BRANCH, OPC_JAL, OPC_JALR: cls = CLS_BRU;
            OPC_OP, OPC_OP_32: begin
                if (funct7 == F7_MULDIV) cls = CLS_MDU;
            end
            default: cls = CLS_ALU;
        endcase
    end

endmodule

// File: rtl/dispatch_queue.sv
// In-order dispatch queue: circular buffer feeding one atomic, in-order group
// per cycle onto slots ALU0/ALU1/MDU/BRU. Optional DISPATCH_STALL_CNT_EN adds perf_stall_cnt.
module dispatch_queue
    import dispatch_pkg::*;
#(
    parameter int QUEUE_DEPTH = 8,
    parameter int ISSUE_NUM   = 4,
    parameter int PC_W        = 64
)(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic [3:0]                in_valid,
    input  logic [3:0][31:0]          in_inst,
    input  logic [3:0][PC_W-1:0]      in_pc,
    output logic                      in_ready,
    output logic [3:0]                out_valid,
    output logic [3:0][31:0]          out_inst,
    output logic [3:0][PC_W-1:0]      out_pc,
    output logic [3:0][1:0]           out_seq,
    input  logic [3:0]                out_ready
`ifdef DISPATCH_STALL_CNT_EN
    ,
    output logic [31:0]               perf_stall_cnt
`endif
);

    localparam int IDX_W = $clog2(QUEUE_DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W-1:0] count;
    logic             q_full;

    logic [31:0]      inst_q [QUEUE_DEPTH];
    logic [31:0]      inst_d [QUEUE_DEPTH];
    logic [PC_W-1:0]  pc_q   [QUEUE_DEPTH];
    logic [PC_W-1:0]  pc_d   [QUEUE_DEPTH];

    logic [ISSUE_NUM-1:0][31:0]     hd_inst;
    logic [ISSUE_NUM-1:0][PC_W-1:0] hd_pc;
    inst_class_e                    hd_cls [ISSUE_NUM];
    logic [IDX_W-1:0]               rd_idx;

    logic [3:0]           grp_valid;
    logic [3:0][31:0]     grp_inst;
    logic [3:0][PC_W-1:0] grp_pc;
    logic [3:0][1:0]      grp_seq;
    logic [2:0]           grp_n;
    logic                 grp_stop;
    logic                 grp_hit;
    logic [1:0]           grp_slot;

    logic                 fire;
    logic                 push_en;
    logic [2:0]           push_n;
    logic [2:0]           pop_n;
    logic [IDX_W-1:0]     wr_idx;

    // Wrap bit distinguishes full from empty when the index bits match.
    assign count    = tail_q - head_q;
    assign q_full   = (tail_q[PTR_W-1] != head_q[PTR_W-1]) &&
                      (tail_q[IDX_W-1:0] == head_q[IDX_W-1:0]);
    assign in_ready = !q_full && (count <= PTR_W'(QUEUE_DEPTH - ISSUE_NUM));

    always_comb begin
        rd_idx = '0;
        for (int k = 0; k < ISSUE_NUM; k++) begin
            rd_idx     = head_q[IDX_W-1:0] + IDX_W'(k);
            hd_inst[k] = inst_q[rd_idx];
            hd_pc[k]   = pc_q[rd_idx];
        end
    end

    for (genvar g = 0; g < ISSUE_NUM; g++) begin : g_cls
        inst_classify u_cls (
            .inst (hd_inst[g]),
            .cls  (hd_cls[g])
        );
    end

    // Walk oldest-first; the first entry that cannot be placed (or any BRU)
    // closes the group so program order within the group is preserved.
    always_comb begin
        grp_valid = '0;
        grp_inst  = '0;
        grp_pc    = '0;
        grp_seq   = '0;
        grp_n     = '0;
        grp_stop  = 1'b0;
        grp_hit   = 1'b0;
        grp_slot  = SLOT_ALU0;
        for (int k = 0; k < ISSUE_NUM; k++) begin
            if (!grp_stop && (PTR_W'(k) < count)) begin
                grp_hit  = 1'b0;
                grp_slot = SLOT_ALU0;
                case (hd_cls[k])
                    CLS_ALU: begin
                        if (!grp_valid[SLOT_ALU0]) begin
                            grp_slot = SLOT_ALU0;
                            grp_hit  = 1'b1;
                        end else if (!grp_valid[SLOT_ALU1]) begin
                            grp_slot = SLOT_ALU1;
                            grp_hit  = 1'b1;
                        end
                    end
                    CLS_MDU: begin
                        grp_slot = SLOT_MDU;
                        grp_hit  = !grp_valid[SLOT_MDU];
                    end
                    CLS_BRU: begin
                        grp_slot = SLOT_BRU;
                        grp_hit  = !grp_valid[SLOT_BRU];
                    end
                    default: grp_hit = 1'b0;
                endcase
                if (grp_hit) begin
                    grp_valid[grp_slot] = 1'b1;
                    grp_inst[grp_slot]  = hd_inst[k];
                    grp_pc[grp_slot]    = hd_pc[k];
                    grp_seq[grp_slot]   = 2'(k);
                    grp_n               = grp_n + 3'd1;
                    if (hd_cls[k] == CLS_BRU) grp_stop = 1'b1;
                end else begin
                    grp_stop = 1'b1;
                end
            end
        end
    end

    assign out_valid = flush ? 4'b0000 : grp_valid;
    assign out_inst  = grp_inst;
    assign out_pc    = grp_pc;
    assign out_seq   = grp_seq;

    assign fire    = !flush && (grp_n != 3'd0) && ((grp_valid & ~out_ready) == 4'b0000);
    assign pop_n   = fire ? grp_n : 3'd0;
    assign push_en = in_ready && !flush && (in_valid != 4'b0000);
    assign push_n  = push_en ? popcount4(in_valid) : 3'd0;

    always_comb begin
        inst_d = inst_q;
        pc_d   = pc_q;
        wr_idx = '0;
        for (int i = 0; i < ISSUE_NUM; i++) begin
            wr_idx = tail_q[IDX_W-1:0] + IDX_W'(i);
            if (push_en && in_valid[i]) begin
                inst_d[wr_idx] = in_inst[i];
                pc_d[wr_idx]   = in_pc[i];
            end
        end
    end

    always_comb begin
        head_d = head_q + PTR_W'(pop_n);
        tail_d = tail_q + PTR_W'(push_n);
        if (flush) begin
            head_d = '0;
            tail_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                inst_q[i] <= '0;
                pc_q[i]   <= '0;
            end
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            inst_q <= inst_d;
            pc_q   <= pc_d;
        end
    end

`ifdef DISPATCH_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // A stall is a presented group that does not fire; flush leaves it intact.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((out_valid != 4'b0000) && !fire && (stall_cnt_q != 32'hFFFF_FFFF))
            stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_cnt_q <= '0;
        else        stall_cnt_q <= stall_cnt_d;
    end

    assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_dispatch_queue.sv
// Self-checking bench for dispatch_queue: reset state, table-driven group
// steering, stall/fill/flush sequences and a randomized queue-model run.
module tb_dispatch_queue;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic [3:0]       in_valid;
    logic [3:0][31:0] in_inst;
    logic [3:0][63:0] in_pc;
    logic             in_ready;
    logic [3:0]       out_valid;
    logic [3:0][31:0] out_inst;
    logic [3:0][63:0] out_pc;
    logic [3:0][1:0]  out_seq;
    logic [3:0]       out_ready;
`ifdef DISPATCH_STALL_CNT_EN
    logic [31:0]      perf_stall_cnt;
`endif

    dispatch_queue #(.QUEUE_DEPTH(8), .ISSUE_NUM(4), .PC_W(64)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_inst(in_inst), .in_pc(in_pc), .in_ready(in_ready),
        .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc), .out_seq(out_seq),
        .out_ready(out_ready)
`ifdef DISPATCH_STALL_CNT_EN
        , .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock; release flush/in_valid after the edge so checks see stable state.
    task automatic cyc();
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 4'b0000;
        #1;
    endtask

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [6:0] f7, input logic [2:0] f3);
        return {f7, 5'd2, 5'd1, f3, 5'd3, op};
    endfunction

    localparam logic [31:0] I_ADD  = {7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33};
    localparam logic [31:0] I_SUB  = {7'h20, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33};
    localparam logic [31:0] I_MUL  = {7'h01, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33};
    localparam logic [31:0] I_DIV  = {7'h01, 5'd2, 5'd1, 3'd4, 5'd3, 7'h33};
    localparam logic [31:0] I_MULW = {7'h01, 5'd2, 5'd1, 3'd0, 5'd3, 7'h3b};
    localparam logic [31:0] I_ADDW = {7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 7'h3b};
    localparam logic [31:0] I_ADDI = {12'h005, 5'd1, 3'd0, 5'd3, 7'h13};
    localparam logic [31:0] I_LW   = {12'h010, 5'd1, 3'd2, 5'd3, 7'h03};
    localparam logic [31:0] I_SW   = {7'h00, 5'd2, 5'd1, 3'd2, 5'd4, 7'h23};
    localparam logic [31:0] I_BEQ  = {7'h00, 5'd2, 5'd1, 3'd0, 5'd8, 7'h63};
    localparam logic [31:0] I_JAL  = {20'h00010, 5'd1, 7'h6f};
    localparam logic [31:0] I_JALR = {12'h000, 5'd1, 3'd0, 5'd1, 7'h67};

    // ---------------- behavioural reference model ----------------
    typedef struct { logic [31:0] inst; logic [63:0] pc; } ent_t;
    ent_t mq[$];

    logic [3:0]       exp_v;
    logic [3:0][31:0] exp_inst;
    logic [3:0][63:0] exp_pc;
    logic [3:0][1:0]  exp_seq;
    int               exp_n;

    // 0 = ALU, 1 = MDU, 2 = BRU
    function automatic int cls_of(input logic [31:0] w);
        logic [6:0] op;
        op = w[6:0];
        if (op == 7'h63 || op == 7'h6f || op == 7'h67) return 2;
        if ((op == 7'h33 || op == 7'h3b) && w[31:25] == 7'h01) return 1;
        return 0;
    endfunction

    task automatic model_group();
        int alus, s, c;
        bit mdu_used, bru_used;
        exp_v = '0; exp_inst = '0; exp_pc = '0; exp_seq = '0; exp_n = 0;
        alus = 0; mdu_used = 0; bru_used = 0;
        for (int k = 0; k < 4 && k < mq.size(); k++) begin
            c = cls_of(mq[k].inst);
            s = -1;
            if (c == 0 && alus < 2)      begin s = alus; alus++; end
            else if (c == 1 && !mdu_used) begin s = 2; mdu_used = 1; end
            else if (c == 2 && !bru_used) begin s = 3; bru_used = 1; end
            if (s < 0) break;
            exp_v[s]    = 1'b1;
            exp_inst[s] = mq[k].inst;
            exp_pc[s]   = mq[k].pc;
            exp_seq[s]  = 2'(k);
            exp_n++;
            if (c == 2) break;
        end
    endtask

    function automatic logic [31:0] rand_inst();
        logic [6:0] ops [12];
        logic [31:0] w;
        ops = '{7'h33, 7'h3b, 7'h13, 7'h1b, 7'h03, 7'h23, 7'h37, 7'h17, 7'h63, 7'h6f, 7'h67, 7'h7f};
        w = $urandom;
        w[6:0] = ops[$urandom_range(0, 11)];
        w[31:25] = ($urandom_range(0, 2) == 0) ? 7'h00 : (($urandom_range(0, 1) == 0) ? 7'h01 : 7'h20);
        return w;
    endfunction

    // ---------------- table-driven vectors ----------------
    typedef struct {
        logic [3:0][31:0] inst;
        logic [3:0]       vin;
        logic [3:0]       v1;
        logic [7:0]       s1;
        logic [3:0]       v2;
        logic [7:0]       s2;
    } vec_t;

    vec_t vt [7];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] r_ready;
        logic [4:0] lanes_mask;
        int nl, fire_m, push_ok, flush_m;
        logic [63:0] pc_ctr;

        vt[0] = '{'{I_BEQ, I_MUL, I_SUB, I_ADD},   4'b1111, 4'b1111, 8'b11_10_01_00, 4'b0000, 8'h00};
        vt[1] = '{'{I_JAL, I_ADDI, I_ADDI, I_ADDI}, 4'b1111, 4'b0011, 8'b00_00_01_00, 4'b1001, 8'b01_00_00_00};
        vt[2] = '{'{I_ADD, I_ADD, I_DIV, I_MUL},   4'b1111, 4'b0100, 8'b00_00_00_00, 4'b0111, 8'b00_00_10_01};
        vt[3] = '{'{I_ADD, I_ADD, I_ADD, I_BEQ},   4'b0011, 4'b1000, 8'b00_00_00_00, 4'b0001, 8'b00_00_00_00};
        vt[4] = '{'{I_MUL, I_SW, I_LW, I_ADD},     4'b1111, 4'b0011, 8'b00_00_01_00, 4'b0101, 8'b00_01_00_00};
        vt[5] = '{'{I_ADD, I_ADD, I_JALR, I_MULW}, 4'b1111, 4'b1100, 8'b01_00_00_00, 4'b0011, 8'b00_00_01_00};
        vt[6] = '{'{I_ADD, I_ADD, I_ADD, I_ADDW},  4'b0001, 4'b0001, 8'b00_00_00_00, 4'b0000, 8'h00};

        rst_n = 1'b0; flush = 1'b0; in_valid = '0; in_inst = '0; in_pc = '0; out_ready = 4'hF;
        #1;
        chk("reset_out_valid", 64'(out_valid), 64'h0);
        chk("reset_in_ready", 64'(in_ready), 64'h1);
        chk("reset_out_inst0", 64'(out_inst[0]), 64'h0);
        chk("reset_out_pc0", out_pc[0], 64'h0);
        chk("reset_out_seq", 64'(out_seq), 64'h0);
        #11 rst_n = 1'b1;

        // mul/div: MDU only, held stable while MDU not ready
        in_inst = '{32'h0, 32'h0, I_DIV, I_MUL}; in_pc = '{64'h0, 64'h0, 64'h44, 64'h40};
        in_valid = 4'b0011; out_ready = 4'b1011;
        cyc();
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", 64'(out_valid), 64'h4);
            chk("stall_inst", 64'(out_inst[2]), 64'(I_MUL));
            chk("stall_in_ready", 64'(in_ready), 64'h1);
            cyc();
        end
        out_ready = 4'hF;
        chk("stall_release_inst", 64'(out_inst[2]), 64'(I_MUL));
        cyc();
        chk("div_valid", 64'(out_valid), 64'h4);
        chk("div_inst", 64'(out_inst[2]), 64'(I_DIV));
        chk("div_pc", out_pc[2], 64'h44);
        cyc();
        chk("muldiv_empty", 64'(out_valid), 64'h0);
`ifdef DISPATCH_STALL_CNT_EN
        chk("stall_cnt", 64'(perf_stall_cnt), 64'd5);
        flush = 1'b1;
        cyc();
        chk("stall_cnt_after_flush", 64'(perf_stall_cnt), 64'd5);
`endif

        // table-driven group steering
        for (int v = 0; v < 7; v++) begin
            flush = 1'b1;
            cyc();
            in_inst = vt[v].inst;
            for (int l = 0; l < 4; l++) in_pc[l] = 64'(32'h1000 * v + 4 * l);
            in_valid = vt[v].vin;
            cyc();
            chk($sformatf("vec%0d_g1_valid", v), 64'(out_valid), 64'(vt[v].v1));
            chk($sformatf("vec%0d_g1_seq", v), 64'(out_seq), 64'(vt[v].s1));
            cyc();
            chk($sformatf("vec%0d_g2_valid", v), 64'(out_valid), 64'(vt[v].v2));
            chk($sformatf("vec%0d_g2_seq", v), 64'(out_seq), 64'(vt[v].s2));
        end

        // fill: in_ready drops at count 8, third push ignored
        flush = 1'b1; cyc();
        out_ready = 4'h0;
        in_inst = '{I_ADD, I_ADD, I_ADD, I_ADD};
        for (int b = 0; b < 3; b++) begin
            for (int l = 0; l < 4; l++) in_pc[l] = 64'(16'h1000 + 16 * b + 4 * l);
            in_valid = 4'b1111;
            cyc();
            chk($sformatf("fill_in_ready%0d", b), 64'(in_ready), (b == 0) ? 64'h1 : 64'h0);
        end
        out_ready = 4'hF;
        for (int g = 0; g < 4; g++) begin
            chk("drain_valid", 64'(out_valid), 64'h3);
            chk("drain_pc0", out_pc[0], 64'(16'h1000 + 8 * g));
            chk("drain_pc1", out_pc[1], 64'(16'h1004 + 8 * g));
            cyc();
        end
        chk("drain_empty", 64'(out_valid), 64'h0);
        chk("drain_in_ready", 64'(in_ready), 64'h1);

        // flush with 6 queued and a simultaneous push
        out_ready = 4'h0;
        in_valid = 4'b1111; cyc();
        in_valid = 4'b0011; cyc();
        chk("pre_flush_in_ready", 64'(in_ready), 64'h0);
        chk("pre_flush_valid", 64'(out_valid), 64'h3);
        flush = 1'b1; in_valid = 4'b1111; in_inst = '{I_BEQ, I_MUL, I_ADD, I_ADD};
        #1;
        chk("flush_cycle_valid", 64'(out_valid), 64'h0);
        cyc();
        chk("post_flush_valid", 64'(out_valid), 64'h0);
        chk("post_flush_in_ready", 64'(in_ready), 64'h1);
        out_ready = 4'hF;
        cyc();
        chk("post_flush_valid2", 64'(out_valid), 64'h0);

        // randomized stream against the queue model
        mq.delete();
        pc_ctr = 64'h8000_0000;
        for (int c = 0; c < 600; c++) begin
            model_group();
            chk("rnd_valid", 64'(out_valid), 64'(exp_v));
            for (int s = 0; s < 4; s++) begin
                if (exp_v[s]) begin
                    chk("rnd_inst", 64'(out_inst[s]), 64'(exp_inst[s]));
                    chk("rnd_pc", out_pc[s], exp_pc[s]);
                    chk("rnd_seq", 64'(out_seq[s]), 64'(exp_seq[s]));
                end
            end
            chk("rnd_in_ready", 64'(in_ready), (mq.size() <= 4) ? 64'h1 : 64'h0);
            r_ready = ($urandom_range(0, 2) != 0) ? 4'hF : 4'($urandom);
            flush_m = ($urandom_range(0, 49) == 0);
            nl = $urandom_range(0, 4);
            lanes_mask = (5'd1 << nl) - 5'd1;
            for (int l = 0; l < 4; l++) begin
                in_inst[l] = rand_inst();
                in_pc[l]   = pc_ctr + 64'(4 * l);
            end
            fire_m  = (exp_n != 0) && ((exp_v & ~r_ready) == 4'b0000) && !flush_m;
            push_ok = (mq.size() <= 4) && !flush_m;
            if (flush_m) begin
                mq.delete();
            end else begin
                if (fire_m) for (int p = 0; p < exp_n; p++) void'(mq.pop_front());
                if (push_ok) begin
                    for (int l = 0; l < nl; l++) mq.push_back('{in_inst[l], in_pc[l]});
                    pc_ctr = pc_ctr + 64'(4 * nl);
                end
            end
            out_ready = r_ready;
            flush     = flush_m[0];
            in_valid  = lanes_mask[3:0];
            cyc();
        end

        // reset mid-operation drops everything
        out_ready = 4'h0;
        in_inst = '{I_ADD, I_ADD, I_ADD, I_ADD};
        in_valid = 4'b1111;
        cyc();
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_valid", 64'(out_valid), 64'h0);
        chk("midreset_in_ready", 64'(in_ready), 64'h1);
        chk("midreset_inst0", 64'(out_inst[0]), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        chk("after_reset_valid", 64'(out_valid), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dispatch_queue.md
# dispatch_queue

In-order instruction buffer and slot-steering stage sitting directly upstream of the main control decoder in the 4-issue RV64 back end. Accepts up to four decoded-width instructions per cycle from the front end, holds them in a circular queue, and each cycle forms one in-order dispatch group steered onto the fixed execution slots (ALU0, ALU1, MDU, BRU), whose opcode/func3 fields feed main control directly. A group fires atomically under a per-slot valid/ready handshake.

## Interface
- QUEUE_DEPTH, 8: entries; power of two, ≥ 2*ISSUE_NUM.
- ISSUE_NUM, 4: front-end width and slot count (fixed at 4).
- PC_W, 64: PC width.
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  discard all queued entries (redirect).
- in_valid  in  [3:0]  per lane; lanes contiguous from 0 (e.g. 4'b0111 legal, 4'b0101 never driven).
- in_inst  in  [3:0][31:0]  instruction words, lane 0 oldest.
- in_pc  in  [3:0][PC_W-1:0]  lane PCs.
- in_ready  out  1  queue has ≥ 4 free entries.
- out_valid  out  [3:0]  slot 0 ALU0, 1 ALU1, 2 MDU, 3 BRU.
- out_inst  out  [3:0][31:0]  slot instruction (opcode = [6:0], func3 = [14:12] to main control).
- out_pc  out  [3:0][PC_W-1:0]  slot PC.
- out_seq  out  [3:0][1:0]  program-order position of slot's instruction within the group.
- out_ready  in  [3:0]  downstream slot can accept.

## Operation
- Classification per entry: BRU = opcode 1100011/1101111/1100111; MDU = opcode 0110011 or 0111011 with funct7 = 0000001; ALU = all other opcodes (R, I, load, store, Rw, Iw, lui, auipc, and unrecognised, which main control decodes to no-write).
- Group formation from head, oldest first, up to 4 entries: ALU takes ALU0, then ALU1; MDU takes slot 2; BRU takes slot 3. Group ends at first entry whose slot is already taken, after a BRU entry, or at queue end. Group depends only on queue contents, never on out_ready.
- fire = (group non-empty) & all slots with out_valid=1 have out_ready=1. On fire head advances by group size; otherwise nothing pops and the same group is presented next cycle unchanged.
- Enqueue: when in_ready & |in_valid, popcount(in_valid) entries written at tail in lane order. Simultaneous enqueue and pop allowed; count_next = count + push − pop.
- Pointers: log2(QUEUE_DEPTH)+1 bits with wrap bit; full when MSBs differ and LSBs equal; index wraps modulo QUEUE_DEPTH.
- in_ready = (count ≤ QUEUE_DEPTH−4), from registered count only.
- flush: next cycle head = tail = 0, count = 0; in the flush cycle out_valid forced 0, no pop, input writes ignored.

## Timing
- Reset (async assert, sync release): head, tail, count = 0; out_valid = 0; in_ready = 1; out_inst/out_pc/out_seq = 0.
- Enqueue-to-dispatch latency: entry written at edge N is presentable in cycle N+1; no bypass.
- out_valid/out_inst/out_pc/out_seq combinational from registered queue state; stable while not fired.
- Throughput: 4 per cycle only for groups like ALU,ALU,MDU,BRU; e.g. three ALUs split 2+1.
- Reset mid-operation: all entries lost, state as above regardless of in-flight fire.

## Configuration
- DISPATCH_STALL_CNT_EN defined: adds output perf_stall_cnt [31:0], incremented (saturating at 32'hFFFF_FFFF) each cycle the group is non-empty and fire = 0; cleared by reset only, not by flush.
- Undefined: port and counter absent; behaviour otherwise identical.

## Structure
- Shared package dispatch_pkg: inst_class_e {CLS_ALU, CLS_MDU, CLS_BRU}, slot index constants SLOT_ALU0..SLOT_BRU, opcode constants reused from the common RV64 opcode definitions, MDU funct7 constant.
- One sub-module: inst_classify (combinational instruction word -> inst_class_e), instantiated per examined head entry.

## Test plan
- Reset then push 4'b1111 of {add, sub, mul, beq} -> next cycle out_valid = 4'b1111, out_seq = {3,2,1,0} for BRU,MDU,ALU1,ALU0; all ready -> count 0 after fire.
- Push {addi, addi, addi, jal} -> group 1: ALU0/ALU1 valid (4'b0011); group 2: ALU0 + BRU (4'b1001).
- Group {mul, div}: cycle 1 MDU only with mul; div in next group; hold out_ready[2] = 0 for 3 cycles -> out_valid/out_inst unchanged, count unchanged.
- Fill: push 4 per cycle with out_ready = 0 -> in_ready drops when count = 8 > 4 i.e. after second push; wrap-around: 20 instructions streamed with random ready emerge in exact program order.
- flush asserted with count = 6 and in_valid = 4'b1111 same cycle -> next cycle count 0, out_valid 0, in_ready 1, no pushed entry appears.
- With DISPATCH_STALL_CNT_EN: 5 stalled cycles then fire -> perf_stall_cnt = 5; flush does not clear it.
